// File: rtl/led_rotate_ctrl.sv
// led_rotate_ctrl: prescaled rotating LED flip-flop bank
// idle/run/pause control, direction select and parallel load
module led_rotate_ctrl #(
  parameter int WIDTH = 8,
  parameter int DIV = 4,
  parameter logic [WIDTH-1:0] INIT = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] led,
  output logic             step,
  output logic             busy
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_d;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_d;
  logic [WIDTH-1:0] led_d;
  logic             rot;
  logic             busy_d;

  // rotation edge: running, prescaler at terminal count, no load
  assign rot = (state == RUN) && (cnt == LAST) && !load;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // next state: stop beats pause beats start; bad codes fall to idle
  always_comb begin
    state_d = IDLE;
    priority case (1'b1)
      stop:
        state_d = IDLE;
      pause && (state == RUN):
        state_d = PAUSE;
      start && (state == IDLE || state == PAUSE):
        state_d = RUN;
      (state == IDLE || state == RUN || state == PAUSE):
        state_d = state;
      default:
        state_d = IDLE;
    endcase
  end

  // busy follows the state being entered
  always_comb begin
    busy_d = (state_d == RUN) || (state_d == PAUSE);
  end

  // prescaler: cleared by load/stop, counts in run, frozen in pause
  always_comb begin
    cnt_d = '0;
    priority case (1'b1)
      load, stop:
        cnt_d = '0;
      state == RUN:
        cnt_d = (cnt == LAST) ? '0 : cnt + CW'(1);
      state == PAUSE:
        cnt_d = cnt;
      default:
        cnt_d = '0;
    endcase
  end

  // bank update: load wins over rotation, otherwise hold
  always_comb begin
    led_d = led;
    priority case (1'b1)
      load:
        led_d = load_val;
      rot && !dir:
        led_d = {led[WIDTH-2:0], led[WIDTH-1]};
      rot && dir:
        led_d = {led[0], led[WIDTH-1:1]};
      default:
        led_d = led;
    endcase
  end

  // datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      led  <= INIT;
      step <= 1'b0;
      busy <= 1'b0;
    end else begin
      cnt  <= cnt_d;
      led  <= led_d;
      step <= rot;
      busy <= busy_d;
    end
  end

endmodule

// File: tb/tb_led_rotate_ctrl.sv
// tb_led_rotate_ctrl: vector table plus scoreboard queue
// second instance exercises the DIV=1 corner
module tb_led_rotate_ctrl;

  localparam int W = 8;

  typedef struct {
    logic         s;
    logic         p;
    logic         t;
    logic         d;
    logic         l;
    logic [W-1:0] lv;
    logic [W-1:0] e_led;
    logic         e_step;
    logic         e_busy;
  } vec_t;

  typedef struct {
    logic [W-1:0] led;
    logic         step;
    logic         busy;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         pause;
  logic         stop;
  logic         dir;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] led;
  logic         step;
  logic         busy;

  logic         start1;
  logic         pause1;
  logic         stop1;
  logic         dir1;
  logic         load1;
  logic [W-1:0] load_val1;
  logic [W-1:0] led1;
  logic         step1;
  logic         busy1;

  int checks;
  int fails;

  vec_t vecs[$];
  exp_t sb[$];

  led_rotate_ctrl #(
    .WIDTH(W),
    .DIV(4),
    .INIT(8'b0000_0001)
  ) u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .pause(pause),
    .stop(stop),
    .dir(dir),
    .load(load),
    .load_val(load_val),
    .led(led),
    .step(step),
    .busy(busy)
  );

  led_rotate_ctrl #(
    .WIDTH(W),
    .DIV(1),
    .INIT(8'b0000_0001)
  ) u_div1 (
    .clk(clk),
    .rst_n(rst_n),
    .start(start1),
    .pause(pause1),
    .stop(stop1),
    .dir(dir1),
    .load(load1),
    .load_val(load_val1),
    .led(led1),
    .step(step1),
    .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rol(input logic [W-1:0] x,
                                       input int n);
    logic [W-1:0] r;
    r = x;
    for (int i = 0; i < n; i++) r = {r[W-2:0], r[W-1]};
    return r;
  endfunction

  function automatic void add(input logic s, input logic p,
                              input logic t, input logic d,
                              input logic l, input logic [W-1:0] lv,
                              input logic [W-1:0] el,
                              input logic es, input logic eb);
    vec_t v;
    v.s = s; v.p = p; v.t = t; v.d = d; v.l = l; v.lv = lv;
    v.e_led = el; v.e_step = es; v.e_busy = eb;
    vecs.push_back(v);
  endfunction

  task automatic run_vec(input vec_t v, input int i);
    exp_t e;
    @(negedge clk);
    start = v.s;
    pause = v.p;
    stop = v.t;
    dir = v.d;
    load = v.l;
    load_val = v.lv;
    e.led = v.e_led;
    e.step = v.e_step;
    e.busy = v.e_busy;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk($sformatf("vec%0d led", i), led, e.led);
    chk($sformatf("vec%0d step", i), {7'd0, step}, {7'd0, e.step});
    chk($sformatf("vec%0d busy", i), {7'd0, busy}, {7'd0, e.busy});
  endtask

  task automatic chk1(input string nm, input logic [W-1:0] el,
                      input logic es, input logic eb);
    chk({nm, " led"}, led1, el);
    chk({nm, " step"}, {7'd0, step1}, {7'd0, es});
    chk({nm, " busy"}, {7'd0, busy1}, {7'd0, eb});
  endtask

  initial begin
    vec_t v;
    checks = 0;
    fails = 0;
    rst_n = 1'b0;
    start = 0; pause = 0; stop = 0; dir = 0; load = 0;
    load_val = '0;
    start1 = 0; pause1 = 0; stop1 = 0; dir1 = 0; load1 = 0;
    load_val1 = '0;

    // idle after reset
    for (int k = 0; k < 10; k++) add(0,0,0,0,0,8'h00, 8'h01,0,0);
    // left rotation through full wrap
    add(1,0,0,0,0,8'h00, 8'h01,0,1);
    for (int k = 1; k <= 32; k++)
      add(0,0,0,0,0,8'h00, rol(8'h01, k/4), (k % 4 == 0), 1);
    add(0,0,1,0,0,8'h00, 8'h01,0,0);
    // right rotation, dir reversed mid-run
    add(1,0,0,1,0,8'h00, 8'h01,0,1);
    for (int k = 0; k < 3; k++) add(0,0,0,1,0,8'h00, 8'h01,0,1);
    add(0,0,0,1,0,8'h00, 8'h80,1,1);
    for (int k = 0; k < 3; k++) add(0,0,0,1,0,8'h00, 8'h80,0,1);
    add(0,0,0,1,0,8'h00, 8'h40,1,1);
    for (int k = 0; k < 3; k++) add(0,0,0,0,0,8'h00, 8'h40,0,1);
    add(0,0,0,0,0,8'h00, 8'h80,1,1);
    for (int k = 0; k < 3; k++) add(0,0,0,1,0,8'h00, 8'h80,0,1);
    add(0,0,0,1,0,8'h00, 8'h40,1,1);
    add(0,0,1,0,0,8'h00, 8'h40,0,0);
    // load while idle
    add(0,0,0,0,1,8'h01, 8'h01,0,0);
    // pause at cnt=2, resume keeps phase
    add(1,0,0,0,0,8'h00, 8'h01,0,1);
    add(0,0,0,0,0,8'h00, 8'h01,0,1);
    add(0,1,0,0,0,8'h00, 8'h01,0,1);
    for (int k = 0; k < 5; k++) add(0,0,0,0,0,8'h00, 8'h01,0,1);
    add(1,0,0,0,0,8'h00, 8'h01,0,1);
    add(0,0,0,0,0,8'h00, 8'h01,0,1);
    add(0,0,0,0,0,8'h00, 8'h02,1,1);
    for (int k = 0; k < 3; k++) add(0,0,0,0,0,8'h00, 8'h02,0,1);
    add(0,0,0,0,0,8'h00, 8'h04,1,1);
    for (int k = 0; k < 3; k++) add(0,0,0,0,0,8'h00, 8'h04,0,1);
    // load at cnt=3 suppresses rotation and restarts prescaler
    add(0,0,0,0,1,8'hA5, 8'hA5,0,1);
    for (int k = 0; k < 3; k++) add(0,0,0,0,0,8'h00, 8'hA5,0,1);
    add(0,0,0,0,0,8'h00, 8'h4B,1,1);
    // pause+start in RUN pauses, then in PAUSE resumes
    add(1,1,0,0,0,8'h00, 8'h4B,0,1);
    add(1,1,0,0,0,8'h00, 8'h4B,0,1);
    add(0,0,0,0,0,8'h00, 8'h4B,0,1);
    add(0,0,0,0,0,8'h00, 8'h4B,0,1);
    add(0,0,0,0,0,8'h00, 8'h96,1,1);
    // stop+start goes idle
    add(1,0,1,0,0,8'h00, 8'h96,0,0);
    add(1,0,1,0,0,8'h00, 8'h96,0,0);
    add(0,0,0,0,0,8'h00, 8'h96,0,0);
    // stop on a rotation edge still rotates
    add(1,0,0,0,0,8'h00, 8'h96,0,1);
    for (int k = 0; k < 3; k++) add(0,0,0,0,0,8'h00, 8'h96,0,1);
    add(0,0,1,0,0,8'h00, 8'h2D,1,0);
    add(0,0,0,0,0,8'h00, 8'h2D,0,0);

    repeat (3) @(negedge clk);
    chk("reset led", led, 8'h01);
    chk("reset step", {7'd0, step}, 8'h00);
    chk("reset busy", {7'd0, busy}, 8'h00);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // async reset right after a rotation edge
    v = '{1,0,0,0,0,8'h00, 8'h2D,0,1};
    run_vec(v, 900);
    v = '{0,0,0,0,0,8'h00, 8'h2D,0,1};
    for (int k = 0; k < 3; k++) run_vec(v, 901 + k);
    v = '{0,0,0,0,0,8'h00, 8'h5A,1,1};
    run_vec(v, 904);
    #2 rst_n = 1'b0;
    #1;
    chk("async led", led, 8'h01);
    chk("async step", {7'd0, step}, 8'h00);
    chk("async busy", {7'd0, busy}, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    v = '{0,0,0,0,0,8'h00, 8'h01,0,0};
    for (int k = 0; k < 4; k++) run_vec(v, 910 + k);

    // DIV=1 instance
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk); #1;
    chk1("d1 start", 8'h01, 0, 1);
    @(negedge clk);
    start1 = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      chk1($sformatf("d1 rot%0d", k), rol(8'h01, k), 1, 1);
    end
    @(negedge clk);
    stop1 = 1'b1;
    @(posedge clk); #1;
    chk1("d1 stop", 8'h10, 1, 0);
    @(negedge clk);
    stop1 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk1($sformatf("d1 hold%0d", k), 8'h10, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
